// File: rtl/vis_pkg.sv
// Shared definitions for visgather: emit FSM encoding, derived width functions
// and the sign-extension helper used by every lane accumulator.
package vis_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam int SEXT_MAX = 32;

    // Output component width: enough headroom that COUNT full-scale frames never wrap.
    function automatic int obits_f(input int width, input int count);
        return width + $clog2(count);
    endfunction

    function automatic int ibits_f(input int length);
        return (length > 1) ? $clog2(length) : 1;
    endfunction

    // Treat the low w bits of v as two's complement and extend to SEXT_MAX bits.
    function automatic logic [SEXT_MAX-1:0] sext(input logic [SEXT_MAX-1:0] v, input int w);
        logic signed [SEXT_MAX-1:0] t;
        t = $signed(v << (SEXT_MAX - w));
        return t >>> (SEXT_MAX - w);
    endfunction

endpackage

// File: rtl/visgather_lane.sv
// One correlator lane: complex running accumulator plus the shadow pair that
// holds the completed window while the top module serialises it.
module visgather_lane
    import vis_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int OBITS = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_valid,
    input  logic             i_first,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_rdata,
    input  logic [WIDTH-1:0] i_idata,
    output logic [OBITS-1:0] o_rdata,
    output logic [OBITS-1:0] o_idata
);

    logic [OBITS-1:0] r_racc;
    logic [OBITS-1:0] r_iacc;
    logic [OBITS-1:0] r_rsh;
    logic [OBITS-1:0] r_ish;
    logic [OBITS-1:0] w_rext;
    logic [OBITS-1:0] w_iext;
    logic [OBITS-1:0] w_rsum;
    logic [OBITS-1:0] w_isum;

    // The first frame of a window restarts the sum instead of adding to stale data.
    always_comb begin
        w_rext = OBITS'(sext(SEXT_MAX'(i_rdata), WIDTH));
        w_iext = OBITS'(sext(SEXT_MAX'(i_idata), WIDTH));
        w_rsum = i_first ? w_rext : (r_racc + w_rext);
        w_isum = i_first ? w_iext : (r_iacc + w_iext);
    end

    // Accumulators and shadow; the shadow captures the final sum including this frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_racc <= {OBITS{1'b0}};
            r_iacc <= {OBITS{1'b0}};
            r_rsh  <= {OBITS{1'b0}};
            r_ish  <= {OBITS{1'b0}};
        end else begin
            if (i_valid) begin
                r_racc <= w_rsum;
                r_iacc <= w_isum;
            end
            if (i_load) begin
                r_rsh <= w_rsum;
                r_ish <= w_isum;
            end
        end
    end

    assign o_rdata = r_rsh;
    assign o_idata = r_ish;

endmodule

// File: rtl/visgather.sv
// Correlator merge-and-accumulate stage: integrates LENGTH lanes over COUNT frames
// and streams the totals out. Define VISGATHER_DROPCOUNT_EN to add drop_count_o.
module visgather
    import vis_pkg::*;
#(
    parameter int LENGTH  = 5,
    parameter int WIDTH   = 7,
    parameter int COUNT   = 30,
    parameter int REVERSE = 0,
    localparam int OBITS  = obits_f(WIDTH, COUNT),
    localparam int IBITS  = ibits_f(LENGTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    par_valid_i,
    input  logic [LENGTH*WIDTH-1:0] par_rdata_i,
    input  logic [LENGTH*WIDTH-1:0] par_idata_i,
    output logic                    seq_valid_o,
    input  logic                    seq_ready_i,
    output logic                    seq_first_o,
    output logic                    seq_last_o,
    output logic [IBITS-1:0]        seq_index_o,
    output logic [OBITS-1:0]        seq_rdata_o,
    output logic [OBITS-1:0]        seq_idata_o,
    output logic                    drop_o,
`ifdef VISGATHER_DROPCOUNT_EN
    output logic [15:0]             drop_count_o,
`endif
    output logic                    busy_o
);

    localparam int FBITS = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [FBITS-1:0] FLAST = FBITS'(COUNT - 1);
    localparam logic [IBITS-1:0] BLAST = IBITS'(LENGTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [FBITS-1:0] r_fcnt;
    logic [IBITS-1:0] r_beat;
    logic [IBITS-1:0] w_idx;
    logic             w_first_frame;
    logic             w_wend;
    logic             w_hs;
    logic             w_last_hs;
    logic             w_free;
    logic             w_load;
    logic             w_drop;
    logic [OBITS-1:0] w_sh_r [LENGTH];
    logic [OBITS-1:0] w_sh_i [LENGTH];

    // Shadow counts as free when the final beat leaves this very cycle, so windows abut.
    always_comb begin
        w_first_frame = (r_fcnt == {FBITS{1'b0}});
        w_wend        = par_valid_i && (r_fcnt == FLAST);
        w_hs          = (r_state == ST_EMIT) && seq_ready_i;
        w_last_hs     = w_hs && (r_beat == BLAST);
        w_free        = (r_state == ST_IDLE) || w_last_hs;
        w_load        = w_wend && w_free;
        w_drop        = w_wend && !w_free;
        w_idx         = (REVERSE != 0) ? (BLAST - r_beat) : r_beat;
    end

    for (genvar g = 0; g < LENGTH; g++) begin : g_lane
        visgather_lane #(
            .WIDTH (WIDTH),
            .OBITS (OBITS)
        ) u_lane (
            .clock   (clock),
            .reset   (reset),
            .i_valid (par_valid_i),
            .i_first (w_first_frame),
            .i_load  (w_load),
            .i_rdata (par_rdata_i[g*WIDTH +: WIDTH]),
            .i_idata (par_idata_i[g*WIDTH +: WIDTH]),
            .o_rdata (w_sh_r[g]),
            .o_idata (w_sh_i[g])
        );
    end

    // Frame counter within the current integration window.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fcnt <= {FBITS{1'b0}};
        end else if (par_valid_i) begin
            r_fcnt <= w_wend ? {FBITS{1'b0}} : (r_fcnt + 1'b1);
        end
    end

    // Emit FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Emit FSM next state; a reload on the final handshake keeps it in EMIT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = w_load ? ST_EMIT : ST_IDLE;
            ST_EMIT: w_state_nxt = (w_last_hs && !w_load) ? ST_IDLE : ST_EMIT;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Beat pointer, counted in emission order and mapped to a lane via w_idx.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_beat <= {IBITS{1'b0}};
        end else if (w_load || w_last_hs) begin
            r_beat <= {IBITS{1'b0}};
        end else if (w_hs) begin
            r_beat <= r_beat + 1'b1;
        end
    end

    // Emit FSM outputs; everything reads zero while idle.
    always_comb begin
        if (r_state == ST_EMIT) begin
            seq_valid_o = 1'b1;
            seq_first_o = (r_beat == {IBITS{1'b0}});
            seq_last_o  = (r_beat == BLAST);
            seq_index_o = w_idx;
            seq_rdata_o = w_sh_r[w_idx];
            seq_idata_o = w_sh_i[w_idx];
            busy_o      = 1'b1;
        end else begin
            seq_valid_o = 1'b0;
            seq_first_o = 1'b0;
            seq_last_o  = 1'b0;
            seq_index_o = {IBITS{1'b0}};
            seq_rdata_o = {OBITS{1'b0}};
            seq_idata_o = {OBITS{1'b0}};
            busy_o      = 1'b0;
        end
    end

`ifdef VISGATHER_DROPCOUNT_EN
    logic [15:0] r_dcnt;

    // Saturating count of discarded windows.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dcnt <= 16'h0000;
        end else if (w_drop && (r_dcnt != 16'hFFFF)) begin
            r_dcnt <= r_dcnt + 16'h0001;
        end
    end

    assign drop_count_o = r_dcnt;
    assign drop_o       = |r_dcnt;
`else
    logic r_drop;

    // Sticky discard flag, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_drop <= 1'b0;
        end else if (w_drop) begin
            r_drop <= 1'b1;
        end
    end

    assign drop_o = r_drop;
`endif

endmodule

// File: tb/tb_visgather.sv
// Self-checking bench for visgather: two COUNT=4 instances (forward and reversed
// lane order) against a window-level reference model, plus a COUNT=30 full-scale instance.
module tb_visgather;

    localparam int L   = 5;
    localparam int W   = 7;
    localparam int C   = 4;
    localparam int OB  = 9;
    localparam int OB2 = 12;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic v0 = 1'b0, rdy0 = 1'b0, v2 = 1'b0, rdy2 = 1'b0;
    logic [L*W-1:0] rbus = '0;
    logic [L*W-1:0] ibus = '0;

    logic          a_valid, a_first, a_last, a_drop, a_busy;
    logic [2:0]    a_index;
    logic [OB-1:0] a_r, a_i;
    logic          b_valid, b_first, b_last, b_drop, b_busy;
    logic [2:0]    b_index;
    logic [OB-1:0] b_r, b_i;
    logic          c_valid, c_first, c_last, c_drop, c_busy;
    logic [2:0]    c_index;
    logic [OB2-1:0] c_r, c_i;
`ifdef VISGATHER_DROPCOUNT_EN
    logic [15:0]   a_dcnt, b_dcnt, c_dcnt;
`endif

    always #5 clock = ~clock;

    visgather #(.LENGTH(L), .WIDTH(W), .COUNT(C), .REVERSE(0)) u_dut_a (
        .clock(clock), .reset(reset), .par_valid_i(v0), .par_rdata_i(rbus), .par_idata_i(ibus),
        .seq_valid_o(a_valid), .seq_ready_i(rdy0), .seq_first_o(a_first), .seq_last_o(a_last),
        .seq_index_o(a_index), .seq_rdata_o(a_r), .seq_idata_o(a_i), .drop_o(a_drop),
`ifdef VISGATHER_DROPCOUNT_EN
        .drop_count_o(a_dcnt),
`endif
        .busy_o(a_busy));

    visgather #(.LENGTH(L), .WIDTH(W), .COUNT(C), .REVERSE(1)) u_dut_b (
        .clock(clock), .reset(reset), .par_valid_i(v0), .par_rdata_i(rbus), .par_idata_i(ibus),
        .seq_valid_o(b_valid), .seq_ready_i(rdy0), .seq_first_o(b_first), .seq_last_o(b_last),
        .seq_index_o(b_index), .seq_rdata_o(b_r), .seq_idata_o(b_i), .drop_o(b_drop),
`ifdef VISGATHER_DROPCOUNT_EN
        .drop_count_o(b_dcnt),
`endif
        .busy_o(b_busy));

    visgather #(.LENGTH(L), .WIDTH(W), .COUNT(30), .REVERSE(0)) u_dut_c (
        .clock(clock), .reset(reset), .par_valid_i(v2), .par_rdata_i(rbus), .par_idata_i(ibus),
        .seq_valid_o(c_valid), .seq_ready_i(rdy2), .seq_first_o(c_first), .seq_last_o(c_last),
        .seq_index_o(c_index), .seq_rdata_o(c_r), .seq_idata_o(c_i), .drop_o(c_drop),
`ifdef VISGATHER_DROPCOUNT_EN
        .drop_count_o(c_dcnt),
`endif
        .busy_o(c_busy));

    wire [25:0] obs_a = {a_valid, a_first, a_last, a_index, a_r, a_i, a_busy, a_drop};
    wire [25:0] obs_b = {b_valid, b_first, b_last, b_index, b_r, b_i, b_busy, b_drop};

    // Reference model: window sums, the latched window and how many beats remain.
    int in_r [L];
    int in_i [L];
    int m_acc_r [L];
    int m_acc_i [L];
    int m_sh_r [L];
    int m_sh_i [L];
    int m_nf = 0;
    int m_rem = 0;
    int m_dcnt = 0;
    bit m_drop = 1'b0;
    int errors = 0;
    int checks = 0;

    function automatic logic [25:0] exp_out(input bit rev);
        int p;
        int idx;
        if (m_rem == 0) begin
            return {1'b0, 1'b0, 1'b0, 3'd0, 9'd0, 9'd0, 1'b0, m_drop};
        end
        p   = L - m_rem;
        idx = rev ? (L - 1 - p) : p;
        return {1'b1, (p == 0), (m_rem == 1), 3'(idx), 9'(m_sh_r[idx]), 9'(m_sh_i[idx]), 1'b1, m_drop};
    endfunction

    task automatic rand_in();
        for (int k = 0; k < L; k++) begin
            in_r[k] = int'($urandom_range(127)) - 64;
            in_i[k] = int'($urandom_range(127)) - 64;
        end
    endtask

    // One clock: drive inputs, advance the model with pre-edge values, sample after the edge.
    task automatic cyc(input bit rst, input bit v, input bit rdy);
        reset = rst;
        v0    = v;
        rdy0  = rdy;
        for (int k = 0; k < L; k++) begin
            rbus[k*W +: W] = 7'(in_r[k]);
            ibus[k*W +: W] = 7'(in_i[k]);
        end
        if (rst) begin
            for (int k = 0; k < L; k++) begin
                m_acc_r[k] = 0; m_acc_i[k] = 0; m_sh_r[k] = 0; m_sh_i[k] = 0;
            end
            m_nf = 0; m_rem = 0; m_dcnt = 0; m_drop = 1'b0;
        end else begin
            if ((m_rem > 0) && rdy) m_rem--;
            if (v) begin
                for (int k = 0; k < L; k++) begin
                    m_acc_r[k] += in_r[k];
                    m_acc_i[k] += in_i[k];
                end
                m_nf++;
                if (m_nf == C) begin
                    m_nf = 0;
                    if (m_rem == 0) begin
                        m_sh_r = m_acc_r;
                        m_sh_i = m_acc_i;
                        m_rem  = L;
                    end else begin
                        m_drop = 1'b1;
                        if (m_dcnt < 65535) m_dcnt++;
                    end
                    for (int k = 0; k < L; k++) begin
                        m_acc_r[k] = 0; m_acc_i[k] = 0;
                    end
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        checks++;
        if (obs_a !== 26'd0) begin
            errors++; $display("FAIL reset_a got=%h exp=%h", obs_a, 26'd0);
        end
        checks++;
        if (obs_b !== 26'd0) begin
            errors++; $display("FAIL reset_b got=%h exp=%h", obs_b, 26'd0);
        end
        checks++;
        if ({c_valid, c_first, c_last, c_index, c_r, c_i, c_busy, c_drop} !== 32'd0) begin
            errors++; $display("FAIL reset_c valid=%b busy=%b drop=%b exp=0", c_valid, c_busy, c_drop);
        end
    endtask

    task automatic test_basic();
        for (int k = 0; k < L; k++) begin
            in_r[k] = k + 1;
            in_i[k] = -(k + 1);
        end
        cyc(1'b0, 1'b0, 1'b1);
        for (int f = 0; f < C; f++) cyc(1'b0, 1'b1, 1'b1);
        for (int b = 0; b < L; b++) begin
            checks++;
            if ({a_valid, a_first, a_last, a_index, a_r, a_i} !==
                {1'b1, (b == 0), (b == L - 1), 3'(b), 9'(4 * (b + 1)), 9'(-4 * (b + 1))}) begin
                errors++;
                $display("FAIL basic_fwd beat=%0d got v=%b f=%b l=%b idx=%0d r=%0d i=%0d exp idx=%0d r=%0d",
                         b, a_valid, a_first, a_last, a_index, $signed(a_r), $signed(a_i), b, 4 * (b + 1));
            end
            checks++;
            if ({b_valid, b_first, b_last, b_index, b_r, b_i} !==
                {1'b1, (b == 0), (b == L - 1), 3'(L - 1 - b), 9'(4 * (L - b)), 9'(-4 * (L - b))}) begin
                errors++;
                $display("FAIL basic_rev beat=%0d got idx=%0d r=%0d exp idx=%0d r=%0d",
                         b, b_index, $signed(b_r), L - 1 - b, 4 * (L - b));
            end
            cyc(1'b0, 1'b0, 1'b1);
        end
        checks++;
        if ({a_valid, a_busy, a_drop} !== 3'b000) begin
            errors++; $display("FAIL basic_idle got=%b exp=000", {a_valid, a_busy, a_drop});
        end
    endtask

    task automatic test_fullscale();
        for (int k = 0; k < L; k++) begin
            in_r[k] = -64;
            in_i[k] = 63;
        end
        v2 = 1'b1; rdy2 = 1'b1;
        for (int f = 0; f < 30; f++) cyc(1'b0, 1'b0, 1'b1);
        v2 = 1'b0;
        for (int b = 0; b < L; b++) begin
            checks++;
            if ({c_valid, c_first, c_last, c_index, c_r, c_i} !==
                {1'b1, (b == 0), (b == L - 1), 3'(b), 12'(-1920), 12'(1890)}) begin
                errors++;
                $display("FAIL fullscale beat=%0d got v=%b idx=%0d r=%0d i=%0d exp r=-1920 i=1890",
                         b, c_valid, c_index, $signed(c_r), $signed(c_i));
            end
            cyc(1'b0, 1'b0, 1'b1);
        end
        checks++;
        if ({c_valid, c_busy, c_drop} !== 3'b000) begin
            errors++; $display("FAIL fullscale_idle got=%b exp=000", {c_valid, c_busy, c_drop});
        end
    endtask

    task automatic test_backpressure();
        cyc(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 3 * C + L + 2; n++) begin
            rand_in();
            cyc(1'b0, n < 3 * C, n >= 3 * C);
            checks++;
            if (obs_a !== exp_out(1'b0)) begin
                errors++; $display("FAIL bp_a cyc=%0d got=%h exp=%h", n, obs_a, exp_out(1'b0));
            end
            checks++;
            if (obs_b !== exp_out(1'b1)) begin
                errors++; $display("FAIL bp_b cyc=%0d got=%h exp=%h", n, obs_b, exp_out(1'b1));
            end
            if (n == 3 * C - 1) begin
                checks++;
                if ({a_valid, a_drop, b_drop} !== 3'b111) begin
                    errors++; $display("FAIL bp_drop got=%b exp=111", {a_valid, a_drop, b_drop});
                end
`ifdef VISGATHER_DROPCOUNT_EN
                checks++;
                if (a_dcnt !== 16'd2) begin
                    errors++; $display("FAIL bp_dcount got=%0d exp=2", a_dcnt);
                end
`endif
            end
        end
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 2 * C + 1 + L + 1; n++) begin
            rand_in();
            cyc(1'b0, (n < C) || ((n > C) && (n <= 2 * C)), 1'b1);
            checks++;
            if (obs_a !== exp_out(1'b0)) begin
                errors++; $display("FAIL b2b_a cyc=%0d got=%h exp=%h", n, obs_a, exp_out(1'b0));
            end
            checks++;
            if (obs_b !== exp_out(1'b1)) begin
                errors++; $display("FAIL b2b_b cyc=%0d got=%h exp=%h", n, obs_b, exp_out(1'b1));
            end
            if (n == 2 * C) begin
                checks++;
                if ({a_valid, a_first, a_drop} !== 3'b110) begin
                    errors++; $display("FAIL b2b_seam got=%b exp=110", {a_valid, a_first, a_drop});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 1'b0, 1'b1);
        for (int f = 0; f < C; f++) begin
            rand_in();
            cyc(1'b0, 1'b1, 1'b1);
        end
        rand_in(); cyc(1'b0, 1'b1, 1'b1);
        rand_in(); cyc(1'b0, 1'b1, 1'b1);
        checks++;
        if ({a_valid, a_index} !== {1'b1, 3'd2}) begin
            errors++; $display("FAIL rmid_pre got v=%b idx=%0d exp v=1 idx=2", a_valid, a_index);
        end
        rand_in(); cyc(1'b1, 1'b1, 1'b1);
        checks++;
        if ({a_valid, a_busy, b_valid, b_busy} !== 4'b0000) begin
            errors++; $display("FAIL rmid_post got=%b exp=0000", {a_valid, a_busy, b_valid, b_busy});
        end
        for (int n = 0; n < C + L + 1; n++) begin
            rand_in();
            cyc(1'b0, n < C, 1'b1);
            checks++;
            if (obs_a !== exp_out(1'b0)) begin
                errors++; $display("FAIL rmid_a cyc=%0d got=%h exp=%h", n, obs_a, exp_out(1'b0));
            end
        end
    endtask

    task automatic test_random();
        cyc(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 400; n++) begin
            rand_in();
            cyc(1'b0, $urandom_range(9) < 7, $urandom_range(1) == 1);
            checks++;
            if (obs_a !== exp_out(1'b0)) begin
                errors++; $display("FAIL rnd_a cyc=%0d got=%h exp=%h", n, obs_a, exp_out(1'b0));
            end
            checks++;
            if (obs_b !== exp_out(1'b1)) begin
                errors++; $display("FAIL rnd_b cyc=%0d got=%h exp=%h", n, obs_b, exp_out(1'b1));
            end
        end
`ifdef VISGATHER_DROPCOUNT_EN
        checks++;
        if (a_dcnt !== 16'(m_dcnt)) begin
            errors++; $display("FAIL rnd_dcount got=%0d exp=%0d", a_dcnt, m_dcnt);
        end
`endif
    endtask

    initial begin
        for (int k = 0; k < L; k++) begin
            in_r[k] = 0; in_i[k] = 0;
            m_acc_r[k] = 0; m_acc_i[k] = 0; m_sh_r[k] = 0; m_sh_i[k] = 0;
        end
        test_reset();
        test_basic();
        test_fullscale();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
